alu_arbiter: RTL

// - Shares the single registered ALU (alu: clk, rst, d1, d2, op, dout) between two requesters.
// - Requester 0 is the integer execute path; requester 1 is the address/branch-compare path.
// - Per requester: valid/ready request handshake and a one-cycle response pulse.
// - Owns and drives the ALU input registers. Does not decode op.
//

---
 rtl/alu_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the execute path (req0) and the address/branch path (req1).
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins every tie); round robin otherwise.
module alu_arbiter #(
  parameter int XLEN    = 32,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_d1,
  input  logic [XLEN-1:0] req0_d2,
  input  logic [OPW-1:0]  req0_op,
  output logic            rsp0_valid,
  output logic [XLEN-1:0] rsp0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_d1,
  input  logic [XLEN-1:0] req1_d2,
  input  logic [OPW-1:0]  req1_op,
  output logic            rsp1_valid,
  output logic [XLEN-1:0] rsp1_data,
  output logic [XLEN-1:0] alu_d1,
  output logic [XLEN-1:0] alu_d2,
  output logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] alu_dout,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int CW = $clog2(ALU_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          grant;
  logic          accept;

  // Handshake: a request transfers on a cycle where reqK_valid and reqK_ready are both high;
  // the requester holds valid and operands stable until then. Responses are a single-cycle
  // rspK_valid pulse with no backpressure; rspK_data holds until the next response to K.

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = ~req0_valid;
  end
`else
  // ptr holds the last grantee; reset to 1 so requester 0 takes the first tie.
  logic ptr;

  always_comb begin
    if (req0_valid && req1_valid) grant = ~ptr;
    else                          grant = ~req0_valid;
  end

  always_ff @(posedge clk) begin
    if (rst)         ptr <= 1'b1;
    else if (accept) ptr <= grant;
  end
`endif

  assign accept     = (state == S_IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // Gated with rst so a reset landing in RESP drops the pulse.
  assign rsp0_valid = (state == S_RESP) && !owner && !rst;
  assign rsp1_valid = (state == S_RESP) && owner && !rst;

  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      alu_d1    <= '0;
      alu_d2    <= '0;
      alu_op    <= '0;
      rsp0_data <= '0;
      rsp1_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_d1 <= grant ? req1_d1 : req0_d1;
            alu_d2 <= grant ? req1_d2 : req0_d2;
            alu_op <= grant ? req1_op : req0_op;
            owner  <= grant;
            cnt    <= CNT_INIT;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            if (owner) rsp1_data <= alu_dout;
            else       rsp0_data <= alu_dout;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
